// File: rtl/field_line_clear_if.sv
// Bus bundle for field_line_clear: start/field request and compacted-field result.
interface field_line_clear_if #(
  parameter int ROWS = 20,
  parameter int COLS = 20,
  parameter int CW   = 5
);
  logic                   start;
  logic [ROWS*COLS-1:0]   field_in;
  logic [ROWS*COLS-1:0]   field_out;
  logic                   busy;
  logic                   done;
  logic [CW-1:0]          lines_cleared;
  logic [15:0]            total_lines;
  logic [19:0]            score;

  modport master (
    output start, field_in,
    input  field_out, busy, done, lines_cleared, total_lines, score
  );

  modport slave (
    input  start, field_in,
    output field_out, busy, done, lines_cleared, total_lines, score
  );
endinterface

// File: rtl/field_line_clear.sv
// Row-clear engine: removes full rows bottom-up, compacting the field one decision per cycle.
// Optional score accumulator enabled by defining FIELD_LINE_CLEAR_SCORE_EN.
module field_line_clear #(
  parameter int ROWS = 20,
  parameter int COLS = 20,
  parameter int CW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  field_line_clear_if.slave bus
);
  localparam int W = ROWS * COLS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   work_q, work_d;
  logic [W-1:0]   field_out_q, field_out_d;
  logic [CW-1:0]  r_q, r_d;
  logic [CW-1:0]  k_q, k_d;
  logic [CW-1:0]  lines_q, lines_d;
  logic [15:0]    total_q, total_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [COLS-1:0] row_cur;
  logic            row_full;
  logic [W-1:0]    work_shifted;

  // Row currently under examination and its full flag
  always_comb begin
    row_cur  = work_q[int'(r_q)*COLS +: COLS];
    row_full = &row_cur;
  end

  // Drop row r: rows 1..r take the row above, row 0 refills with zeros
  always_comb begin
    work_shifted = {W{1'b0}};
    for (int i = 1; i < ROWS; i++) begin
      if (i <= int'(r_q)) begin
        work_shifted[i*COLS +: COLS] = work_q[(i-1)*COLS +: COLS];
      end else begin
        work_shifted[i*COLS +: COLS] = work_q[i*COLS +: COLS];
      end
    end
  end

  // Next-state and datapath decisions
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    field_out_d = field_out_q;
    r_d         = r_q;
    k_d         = k_q;
    lines_d     = lines_q;
    total_d     = total_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.field_in;
          r_d     = CW'(ROWS - 1);
          k_d     = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = SCAN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      SCAN: begin
        if (row_full) begin
          // Same index is re-examined since a new row has dropped into it
          work_d = work_shifted;
          k_d    = k_q + {{(CW-1){1'b0}}, 1'b1};
        end else if (r_q != {CW{1'b0}}) begin
          r_d    = r_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          field_out_d = work_q;
          lines_d     = k_q;
          total_d     = total_q + 16'(k_q);
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= {W{1'b0}};
      field_out_q <= {W{1'b0}};
      r_q         <= {CW{1'b0}};
      k_q         <= {CW{1'b0}};
      lines_q     <= {CW{1'b0}};
      total_q     <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      field_out_q <= field_out_d;
      r_q         <= r_d;
      k_q         <= k_d;
      lines_q     <= lines_d;
      total_q     <= total_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef FIELD_LINE_CLEAR_SCORE_EN
  logic [19:0] score_q, score_d;
  logic [20:0] score_sum;

  function automatic logic [19:0] score_pts(input logic [CW-1:0] k);
    logic [31:0] kk;
    kk = 32'(k);
    case (kk)
      32'd0:   score_pts = 20'd0;
      32'd1:   score_pts = 20'd40;
      32'd2:   score_pts = 20'd100;
      32'd3:   score_pts = 20'd300;
      default: score_pts = 20'd1200;
    endcase
  endfunction

  // Saturating score update on the completing edge
  always_comb begin
    score_sum = {1'b0, score_q} + {1'b0, score_pts(k_q)};
    score_d   = score_q;
    if (done_d) begin
      score_d = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    end else begin
      score_d = score_q;
    end
  end

  // Score register
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= 20'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign bus.score = score_q;
`else
  assign bus.score = 20'd0;
`endif

  assign bus.field_out     = field_out_q;
  assign bus.lines_cleared = lines_q;
  assign bus.total_lines   = total_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_field_line_clear.sv
// Scoreboard bench for field_line_clear: stimulus pushes reference results, a monitor pops on done.
module tb_field_line_clear;
  localparam int ROWS = 20;
  localparam int COLS = 20;
  localparam int CW   = 5;
  localparam int W    = ROWS * COLS;

  typedef struct {
    logic [W-1:0] field;
    int           k;
    int           total;
    int           score;
    int           done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_total = 0;
  int   m_score = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  field_line_clear_if #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) bus ();

  field_line_clear #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: keep non-full rows in bottom-up order, restack them from the bottom.
  function automatic void ref_clear(input logic [W-1:0] f, output logic [W-1:0] o, output int k);
    logic [COLS-1:0] kept[$];
    logic [COLS-1:0] row;
    k = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = f[r*COLS +: COLS];
      if (row == {COLS{1'b1}}) k++;
      else kept.push_back(row);
    end
    o = '0;
    for (int i = 0; i < kept.size(); i++) o[(ROWS-1-i)*COLS +: COLS] = kept[i];
  endfunction

  function automatic int points(input int k);
    if (k == 0) return 0;
    if (k == 1) return 40;
    if (k == 2) return 100;
    if (k == 3) return 300;
    return 1200;
  endfunction

  function automatic logic [W-1:0] set_row(input logic [W-1:0] f, input int r, input logic [COLS-1:0] v);
    logic [W-1:0] t;
    t = f;
    t[r*COLS +: COLS] = v;
    return t;
  endfunction

  // Called at a negedge: drive start for one cycle and enqueue the expected result.
  task automatic issue(input logic [W-1:0] f);
    exp_t e;
    logic [W-1:0] o;
    int k;
    ref_clear(f, o, k);
    m_total = (m_total + k) % 65536;
`ifdef FIELD_LINE_CLEAR_SCORE_EN
    m_score = m_score + points(k);
    if (m_score > 1048575) m_score = 1048575;
`endif
    e.field = o; e.k = k; e.total = m_total; e.score = m_score;
    e.done_cyc = cyc + 1 + ROWS + k;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.field_in = f;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_rise", W'(bus.busy), W'(1));
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got=no_done expected=done");
    end
  endtask

  // Monitor: compare every completed result against the scoreboard head
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=done expected=none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("field_out", bus.field_out, e.field);
        check("lines_cleared", W'(bus.lines_cleared), W'(e.k));
        check("total_lines", W'(bus.total_lines), W'(e.total));
        check("score", W'(bus.score), W'(e.score));
        check("latency", W'(cyc), W'(e.done_cyc));
        check("busy_fall", W'(bus.busy), W'(0));
      end
    end
    if (prev_done && bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_width got=2cycles expected=1cycle");
    end
    prev_done = bus.done;
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_field_out"}, bus.field_out, W'(0));
    check({tag, "_lines"}, W'(bus.lines_cleared), W'(0));
    check({tag, "_total"}, W'(bus.total_lines), W'(0));
    check({tag, "_score"}, W'(bus.score), W'(0));
    check({tag, "_busy"}, W'(bus.busy), W'(0));
    check({tag, "_done"}, W'(bus.done), W'(0));
  endtask

  logic [W-1:0] f;
  logic [W-1:0] three;
  logic [W-1:0] one;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.field_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("reset");

    // Empty field
    issue('0);
    wait_done();

    // Bottom row full, single block above
    f = '0;
    f = set_row(f, 19, 20'hFFFFF);
    f = set_row(f, 18, 20'h00001);
    one = f;
    issue(f);
    wait_done();

    // Three full rows around a partial one
    f = '0;
    f = set_row(f, 19, 20'hFFFFF);
    f = set_row(f, 18, 20'h0F0F0);
    f = set_row(f, 17, 20'hFFFFF);
    f = set_row(f, 16, 20'hFFFFF);
    f = set_row(f, 15, 20'h00003);
    three = f;
    issue(f);
    wait_done();

    // Completely full field
    issue({W{1'b1}});
    wait_done();

    // Start while busy must be ignored
    issue(three);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.field_in = {W{1'b1}};
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (50) @(negedge clk);

    // Reset in the middle of a scan aborts it
    issue(three);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_total = 0;
    m_score = 0;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("abort");
    repeat (40) @(negedge clk);

    // Back-to-back: start accepted in the done cycle, totals accumulate 3 then 4
    issue(three);
    wait_done();
    issue(one);
    wait_done();

    // Randomized fields with random gaps
    for (int n = 0; n < 30; n++) begin
      f = '0;
      for (int r = 0; r < ROWS; r++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 3) f = set_row(f, r, 20'hFFFFF);
        else if (sel < 5) f = set_row(f, r, 20'h00000);
        else f = set_row(f, r, 20'($urandom));
      end
      issue(f);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (30) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
